// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM with registered outputs.
// Optional power-on clear sweep of the whole RAM is enabled by defining RAM_CLEAR_EN.
module ram_arbiter #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_in,
   output logic              ram_ld,
   input  logic [DATA_W-1:0] ram_out
);

`ifdef RAM_CLEAR_EN
   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS} state_t;
   localparam state_t RST_STATE = S_CLEAR;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
`else
   typedef enum logic {S_IDLE, S_ACCESS} state_t;
   localparam state_t RST_STATE = S_IDLE;
`endif

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_in_q, ram_in_d;
   logic              ram_ld_q, ram_ld_d;
   logic              pick1;

   // last_q = 1 means port 1 was granted last, so port 0 wins the next tie
   assign pick1 = req1 & (~req0 | ~last_q);

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      rdata_d    = rdata_q;
      ram_addr_d = ram_addr_q;
      ram_in_d   = ram_in_q;
      ram_ld_d   = 1'b0;
`ifdef RAM_CLEAR_EN
      cnt_d      = cnt_q;
      busy_d     = busy_q;
`endif
      case (state_q)
`ifdef RAM_CLEAR_EN
         S_CLEAR: begin
            // busy_q low here marks the single exit cycle after the last write
            if (busy_q) begin
               ram_ld_d   = 1'b1;
               ram_in_d   = '0;
               ram_addr_d = cnt_q;
               cnt_d      = cnt_q + 1'b1;
               if (&cnt_q) busy_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
`endif
         S_IDLE: begin
            if (req0 | req1) begin
               gnt0_d     = ~pick1;
               gnt1_d     = pick1;
               last_d     = pick1;
               ram_addr_d = pick1 ? addr1  : addr0;
               ram_in_d   = pick1 ? wdata1 : wdata0;
               ram_ld_d   = pick1 ? we1    : we0;
               state_d    = S_ACCESS;
            end
         end
         S_ACCESS: begin
            state_d = S_IDLE;
            if (!ram_ld_q) begin
               rdata_d   = ram_out;
               rvalid0_d = gnt0_q;
               rvalid1_d = gnt1_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RST_STATE;
         last_q     <= 1'b1;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata_q    <= '0;
         ram_addr_q <= '0;
         ram_in_q   <= '0;
         ram_ld_q   <= 1'b0;
`ifdef RAM_CLEAR_EN
         cnt_q      <= '0;
         busy_q     <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
         rdata_q    <= rdata_d;
         ram_addr_q <= ram_addr_d;
         ram_in_q   <= ram_in_d;
         ram_ld_q   <= ram_ld_d;
`ifdef RAM_CLEAR_EN
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
`endif
      end
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata    = rdata_q;
   assign ram_addr = ram_addr_q;
   assign ram_in   = ram_in_q;
   assign ram_ld   = ram_ld_q;
`ifdef RAM_CLEAR_EN
   assign busy     = busy_q;
`else
   assign busy     = 1'b0;
`endif

endmodule
